// File: rtl/mem_bus_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_if
//  Description : Bundle of the two requester ports (instruction fetch m0,
//                load/store m1) and the shared memory port around the
//                mem_bus_arbiter. "slave" is the arbiter's view; "master"
//                is the view of whatever sits around it (masters + memory).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  // m0: instruction-fetch, read only
  logic              m0_req;
  logic [AW-1:0]     m0_addr;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DW-1:0]     m0_rdata;
  logic              m0_err;

  // m1: load/store
  logic              m1_req;
  logic              m1_we;
  logic [AW-1:0]     m1_addr;
  logic [DW-1:0]     m1_wdata;
  logic [DW/8-1:0]   m1_be;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DW-1:0]     m1_rdata;
  logic              m1_err;

  // shared memory port
  logic              s_req;
  logic              s_we;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [DW/8-1:0]   s_be;
  logic              s_rvalid;
  logic [DW-1:0]     s_rdata;

  // arbiter side
  modport slave (
    input  m0_req, m0_addr,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_be,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output s_req, s_we, s_addr, s_wdata, s_be,
    input  s_rvalid, s_rdata
  );

  // requesters + memory side
  modport master (
    output m0_req, m0_addr,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_be,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  s_req, s_we, s_addr, s_wdata, s_be,
    output s_rvalid, s_rdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Two-requester arbiter onto one memory port with a single
//                outstanding transaction. m1 (load/store) has priority,
//                bounded by a streak guard so m0 (fetch) is never starved.
//                A response timeout returns an error to the owner when the
//                memory stays silent for TMO cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 15
) (
  input  wire        clk,
  input  wire        rst_n,
  mem_bus_if.slave   bus
);

  localparam int         c_BW       = DW / 8;
  // Counter value seen in the last silent cycle before the timeout fires:
  // the grant cycle clears it, so the TMO-th cycle after grant sees TMO-1.
  localparam logic [7:0] c_TMO_LAST = 8'(TMO - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  streak_q, streak_d;
  logic [7:0]  tmo_q, tmo_d;

  logic        w_busy;
  logic        w_resp;
  logic        w_tmo_hit;
  logic        w_can_grant;
  logic        w_m0_first;
  logic        w_gnt0;
  logic        w_gnt1;

  // Grant decision. Gating with rst_n keeps every output at zero while reset
  // is held, even though requests may already be present.
  assign w_busy      = (state_q == ST_BUSY0) || (state_q == ST_BUSY1);
  assign w_resp      = w_busy && bus.s_rvalid;
  assign w_tmo_hit   = w_busy && !bus.s_rvalid && (tmo_q == c_TMO_LAST);
  assign w_can_grant = rst_n && ((state_q == ST_IDLE) || w_resp);
  assign w_m0_first  = bus.m0_req && (streak_q == 2'd3);
  assign w_gnt1      = w_can_grant && bus.m1_req && !w_m0_first;
  assign w_gnt0      = w_can_grant && bus.m0_req && !w_gnt1;

  // State, starvation streak and timeout counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      streak_q <= 2'd0;
      tmo_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      tmo_q    <= tmo_d;
    end
  end

  // Next-state, response routing and memory-port drive
  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    tmo_d         = tmo_q;

    bus.m0_gnt    = w_gnt0;
    bus.m1_gnt    = w_gnt1;
    bus.m0_rvalid = 1'b0;
    bus.m0_rdata  = {DW{1'b0}};
    bus.m0_err    = 1'b0;
    bus.m1_rvalid = 1'b0;
    bus.m1_rdata  = {DW{1'b0}};
    bus.m1_err    = 1'b0;

    bus.s_req     = w_gnt0 || w_gnt1;
    bus.s_we      = 1'b0;
    bus.s_addr    = {AW{1'b0}};
    bus.s_wdata   = {DW{1'b0}};
    bus.s_be      = {c_BW{1'b0}};

    // Memory port carries the winner's payload; m0 is always a full read.
    if (w_gnt1) begin
      bus.s_we    = bus.m1_we;
      bus.s_addr  = bus.m1_addr;
      bus.s_wdata = bus.m1_wdata;
      bus.s_be    = bus.m1_be;
    end else if (w_gnt0) begin
      bus.s_addr  = bus.m0_addr;
      bus.s_be    = {c_BW{1'b1}};
    end

    // Route a memory response (or a timeout error) back to the owner.
    // s_rvalid in IDLE is a stale answer to a timed-out access: dropped.
    if (state_q == ST_BUSY0) begin
      if (bus.s_rvalid) begin
        bus.m0_rvalid = 1'b1;
        bus.m0_rdata  = bus.s_rdata;
      end else if (w_tmo_hit) begin
        bus.m0_rvalid = 1'b1;
        bus.m0_err    = 1'b1;
      end
    end else if (state_q == ST_BUSY1) begin
      if (bus.s_rvalid) begin
        bus.m1_rvalid = 1'b1;
        bus.m1_rdata  = bus.s_rdata;
      end else if (w_tmo_hit) begin
        bus.m1_rvalid = 1'b1;
        bus.m1_err    = 1'b1;
      end
    end

    // Transaction tracking: a grant always opens a fresh transaction, a
    // response without a follow-on grant or a timeout closes it.
    if (w_tmo_hit) begin
      state_d = ST_IDLE;
      tmo_d   = 8'd0;
    end else if (w_gnt0) begin
      state_d = ST_BUSY0;
      tmo_d   = 8'd0;
    end else if (w_gnt1) begin
      state_d = ST_BUSY1;
      tmo_d   = 8'd0;
    end else if (w_resp) begin
      state_d = ST_IDLE;
    end else if (w_busy) begin
      tmo_d   = tmo_q + 8'd1;
    end

    // Streak counts consecutive m1 wins that made m0 wait.
    if (!bus.m0_req || w_gnt0) begin
      streak_d = 2'd0;
    end else if (w_gnt1 && (streak_q != 2'd3)) begin
      streak_d = streak_q + 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Directed, table-driven bench for mem_bus_arbiter plus
//                hand-written timeout and mid-transaction reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mem_bus_if #(.AW(AW), .DW(DW)) bus ();

  mem_bus_arbiter #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        m0_req;
    logic [31:0] m0_addr;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_be;
    logic        s_rvalid;
    logic [31:0] s_rdata;
  } in_t;

  typedef struct packed {
    logic        m0_gnt;
    logic        m1_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m0_err;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    logic        m1_err;
    logic        s_req;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_be;
  } out_t;

  typedef struct {
    string name;
    in_t   in;
    out_t  exp;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];

  function automatic in_t mi(input logic m0r, input logic [31:0] m0a,
                             input logic m1r, input logic m1we,
                             input logic [31:0] m1a, input logic [31:0] m1wd,
                             input logic [3:0] m1be,
                             input logic srv, input logic [31:0] srd);
    in_t r;
    r = '{m0r, m0a, m1r, m1we, m1a, m1wd, m1be, srv, srd};
    return r;
  endfunction

  function automatic out_t mo(input logic g0, input logic g1,
                              input logic rv0, input logic [31:0] rd0, input logic e0,
                              input logic rv1, input logic [31:0] rd1, input logic e1,
                              input logic sreq, input logic swe,
                              input logic [31:0] sa, input logic [31:0] swd,
                              input logic [3:0] sbe);
    out_t r;
    r = '{g0, g1, rv0, rd0, e0, rv1, rd1, e1, sreq, swe, sa, swd, sbe};
    return r;
  endfunction

  function automatic out_t zero_out();
    return mo(0,0, 0,32'h0,0, 0,32'h0,0, 0,0,32'h0,32'h0,4'h0);
  endfunction

  task automatic add(input string n, input in_t i, input out_t e);
    vec_t v;
    v.name = n;
    v.in   = i;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input in_t i);
    bus.m0_req   = i.m0_req;
    bus.m0_addr  = i.m0_addr;
    bus.m1_req   = i.m1_req;
    bus.m1_we    = i.m1_we;
    bus.m1_addr  = i.m1_addr;
    bus.m1_wdata = i.m1_wdata;
    bus.m1_be    = i.m1_be;
    bus.s_rvalid = i.s_rvalid;
    bus.s_rdata  = i.s_rdata;
  endtask

  task automatic check(input string n, input out_t e);
    out_t a;
    a = {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m0_rdata, bus.m0_err,
         bus.m1_rvalid, bus.m1_rdata, bus.m1_err,
         bus.s_req, bus.s_we, bus.s_addr, bus.s_wdata, bus.s_be};
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled mid-cycle.
  task automatic cycle(input string n, input in_t i, input out_t e);
    drive(i);
    @(negedge clk);
    check(n, e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_t  idle_in;
    in_t  both_in;
    idle_in = mi(0,32'h0, 0,0,32'h0,32'h0,4'h0, 0,32'h0);

    // ---- vector table -----------------------------------------------------
    // m0 read, memory answers next cycle (first cycle after reset release)
    add("m0_rd_gnt",  mi(1,32'h10, 0,0,32'h0,32'h0,4'h0, 0,32'h0),
                      mo(1,0, 0,32'h0,0, 0,32'h0,0, 1,0,32'h10,32'h0,4'hF));
    add("m0_rd_resp", mi(0,32'h0, 0,0,32'h0,32'h0,4'h0, 1,32'h12345678),
                      mo(0,0, 1,32'h12345678,0, 0,32'h0,0, 0,0,32'h0,32'h0,4'h0));
    // m1 partial write and its acknowledge
    add("m1_wr_gnt",  mi(0,32'h0, 1,1,32'h20,32'hAABBCCDD,4'h3, 0,32'h0),
                      mo(0,1, 0,32'h0,0, 0,32'h0,0, 1,1,32'h20,32'hAABBCCDD,4'h3));
    add("m1_wr_ack",  mi(0,32'h0, 0,0,32'h0,32'h0,4'h0, 1,32'hDEAD0001),
                      mo(0,0, 0,32'h0,0, 1,32'hDEAD0001,0, 0,0,32'h0,32'h0,4'h0));
    // stray response while idle is dropped
    add("idle_stray", mi(0,32'h0, 0,0,32'h0,32'h0,4'h0, 1,32'h55),
                      zero_out());
    // both request continuously: m1,m1,m1,m0 pattern
    add("both_0_m1",  mi(1,32'h100, 1,0,32'h200,32'h0,4'hF, 0,32'h0),
                      mo(0,1, 0,32'h0,0, 0,32'h0,0, 1,0,32'h200,32'h0,4'hF));
    add("both_1_m1",  mi(1,32'h100, 1,0,32'h200,32'h0,4'hF, 1,32'hA1),
                      mo(0,1, 0,32'h0,0, 1,32'hA1,0, 1,0,32'h200,32'h0,4'hF));
    add("both_2_m1",  mi(1,32'h100, 1,0,32'h200,32'h0,4'hF, 1,32'hA2),
                      mo(0,1, 0,32'h0,0, 1,32'hA2,0, 1,0,32'h200,32'h0,4'hF));
    add("both_3_m0",  mi(1,32'h100, 1,0,32'h200,32'h0,4'hF, 1,32'hA3),
                      mo(1,0, 0,32'h0,0, 1,32'hA3,0, 1,0,32'h100,32'h0,4'hF));
    add("both_4_m1",  mi(1,32'h100, 1,0,32'h200,32'h0,4'hF, 1,32'hA4),
                      mo(0,1, 1,32'hA4,0, 0,32'h0,0, 1,0,32'h200,32'h0,4'hF));
    add("both_5_m1",  mi(1,32'h100, 1,0,32'h200,32'h0,4'hF, 1,32'hA5),
                      mo(0,1, 0,32'h0,0, 1,32'hA5,0, 1,0,32'h200,32'h0,4'hF));
    add("both_6_m1",  mi(1,32'h100, 1,0,32'h200,32'h0,4'hF, 1,32'hA6),
                      mo(0,1, 0,32'h0,0, 1,32'hA6,0, 1,0,32'h200,32'h0,4'hF));
    add("both_7_m0",  mi(1,32'h100, 1,0,32'h200,32'h0,4'hF, 1,32'hA7),
                      mo(1,0, 0,32'h0,0, 1,32'hA7,0, 1,0,32'h100,32'h0,4'hF));
    // busy, memory silent: no grant
    add("busy_hold",  mi(1,32'h100, 1,0,32'h200,32'h0,4'hF, 0,32'h0),
                      zero_out());
    add("m0_resp_m1", mi(0,32'h0, 1,0,32'h200,32'h0,4'hF, 1,32'hA8),
                      mo(0,1, 1,32'hA8,0, 0,32'h0,0, 1,0,32'h200,32'h0,4'hF));
    add("m1_resp",    mi(0,32'h0, 0,0,32'h0,32'h0,4'h0, 1,32'hA9),
                      mo(0,0, 0,32'h0,0, 1,32'hA9,0, 0,0,32'h0,32'h0,4'h0));

    // ---- reset state with requests present --------------------------------
    both_in = mi(1,32'h10, 1,1,32'h20,32'hFFFF,4'hF, 1,32'h77);
    drive(both_in);
    #2;
    check("reset_outs", zero_out());
    drive(idle_in);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ---- table ------------------------------------------------------------
    foreach (vecs[k]) begin
      cycle(vecs[k].name, vecs[k].in, vecs[k].exp);
    end

    // ---- timeout: m0 read never answered ----------------------------------
    cycle("t_gnt", mi(1,32'h40, 0,0,32'h0,32'h0,4'h0, 0,32'h0),
                   mo(1,0, 0,32'h0,0, 0,32'h0,0, 1,0,32'h40,32'h0,4'hF));
    for (int k = 1; k < TMO; k++) begin
      cycle($sformatf("t_wait%0d", k), idle_in, zero_out());
    end
    cycle("t_hit",  mi(0,32'h0, 1,0,32'h44,32'h0,4'hF, 0,32'h0),
                    mo(0,0, 1,32'h0,1, 0,32'h0,0, 0,0,32'h0,32'h0,4'h0));
    cycle("t_late", mi(0,32'h0, 1,0,32'h44,32'h0,4'hF, 1,32'hBAD),
                    mo(0,1, 0,32'h0,0, 0,32'h0,0, 1,0,32'h44,32'h0,4'hF));
    cycle("t_ack",  mi(0,32'h0, 0,0,32'h0,32'h0,4'h0, 1,32'h66),
                    mo(0,0, 0,32'h0,0, 1,32'h66,0, 0,0,32'h0,32'h0,4'h0));

    // ---- reset while m1 outstanding ---------------------------------------
    cycle("r_gnt1", mi(0,32'h0, 1,0,32'h80,32'h0,4'hF, 0,32'h0),
                    mo(0,1, 0,32'h0,0, 0,32'h0,0, 1,0,32'h80,32'h0,4'hF));
    drive(mi(1,32'h90, 0,0,32'h0,32'h0,4'h0, 1,32'h77));
    rst_n = 1'b0;
    #1;
    check("r_async", zero_out());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle("r_first", mi(1,32'h90, 0,0,32'h0,32'h0,4'h0, 1,32'h77),
                     mo(1,0, 0,32'h0,0, 0,32'h0,0, 1,0,32'h90,32'h0,4'hF));
    cycle("r_resp",  mi(0,32'h0, 0,0,32'h0,32'h0,4'h0, 1,32'h99),
                     mo(0,0, 1,32'h99,0, 0,32'h0,0, 0,0,32'h0,32'h0,4'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
